// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU program sequencer: default sizes, the
// sequencer state encoding and the branch-target helper.
package mpu_pkg;

    localparam int PM_ADDR_W_DEF   = 8;
    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        SEQ_RESET = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_HOLD  = 2'd2
    } seq_state_t;

    // Branch targets are always 16-word aligned: the decoder nibble selects the page.
    function automatic logic [7:0] branch_target(input logic [3:0] nibble);
        return {nibble, 4'h0};
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for call/ret. Overflowing pushes and underflowing
// pops are ignored here; the sequencer flags them.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_idx_s;
    logic [PTR_W-1:0] rd_idx_s;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == CNT_W'(0));
    assign wr_idx_s = PTR_W'(count_q);
    assign rd_idx_s = PTR_W'(count_q - CNT_W'(1));
    assign data_o   = mem_q[rd_idx_s];

    // Stack storage and occupancy; reset discards every entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(0);
            end
        end else if (push_i && !full_o) begin
            mem_q[wr_idx_s] <= data_i;
            count_q         <= count_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            count_q <= count_q - CNT_W'(1);
        end else begin
            count_q <= count_q;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program-memory address sequencer: increment, jump, conditional jump,
// call/ret through a return stack, and a stall that freezes all state.
module program_sequencer
    import mpu_pkg::*;
#(
    parameter int PM_ADDR_W   = PM_ADDR_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 jmp,
    input  logic                 jmp_nz,
    input  logic [3:0]           jmp_addr,
    input  logic                 dont_jmp,
    input  logic                 call,
    input  logic                 ret,
    input  logic                 hold,
    output logic [PM_ADDR_W-1:0] pm_addr,
    output logic [PM_ADDR_W-1:0] pc,
    output logic                 stack_err,
    output logic [1:0]           state
);

    seq_state_t           state_q;
    logic [PM_ADDR_W-1:0] pm_addr_q;
    logic [PM_ADDR_W-1:0] pm_addr_d;
    logic [PM_ADDR_W-1:0] pc_q;
    logic                 stack_err_q;
    logic                 stack_err_d;

    logic                 active_s;
    logic                 push_s;
    logic                 pop_s;
    logic [PM_ADDR_W-1:0] target_s;
    logic [PM_ADDR_W-1:0] inc_s;
    logic [PM_ADDR_W-1:0] ret_addr_s;
    logic [PM_ADDR_W-1:0] stack_top_s;
    logic                 stack_full_s;
    logic                 stack_empty_s;

    assign active_s   = (state_q != SEQ_RESET) && !hold;
    assign target_s   = PM_ADDR_W'(branch_target(jmp_addr));
    assign inc_s      = pm_addr_q + PM_ADDR_W'(1);
    assign ret_addr_s = pc_q + PM_ADDR_W'(1);

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PM_ADDR_W)
    ) u_return_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (ret_addr_s),
        .data_o  (stack_top_s),
        .full_o  (stack_full_s),
        .empty_o (stack_empty_s)
    );

    // Next-address mux: ret > call > jmp > jmp_nz > increment; ret beats call so a
    // simultaneous pair never pushes.
    always_comb begin
        pm_addr_d   = inc_s;
        stack_err_d = stack_err_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (!active_s) begin
            pm_addr_d = pm_addr_q;
        end else if (ret) begin
            if (stack_empty_s) begin
                stack_err_d = 1'b1;
            end else begin
                pop_s     = 1'b1;
                pm_addr_d = stack_top_s;
            end
        end else if (call) begin
            pm_addr_d = target_s;
            if (stack_full_s) begin
                stack_err_d = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else if (jmp || (jmp_nz && !dont_jmp)) begin
            pm_addr_d = target_s;
        end else begin
            pm_addr_d = inc_s;
        end
    end

    // Sequencer FSM with registered address, pc, error and state outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SEQ_RESET;
            pm_addr_q   <= PM_ADDR_W'(0);
            pc_q        <= PM_ADDR_W'(0);
            stack_err_q <= 1'b0;
        end else begin
            case (state_q)
                SEQ_RESET: begin
                    state_q   <= SEQ_RUN;
                    pm_addr_q <= PM_ADDR_W'(0);
                    pc_q      <= pm_addr_q;
                end
                SEQ_RUN, SEQ_HOLD: begin
                    if (hold) begin
                        state_q <= SEQ_HOLD;
                    end else begin
                        state_q     <= SEQ_RUN;
                        pm_addr_q   <= pm_addr_d;
                        pc_q        <= pm_addr_q;
                        stack_err_q <= stack_err_d;
                    end
                end
                default: begin
                    state_q <= SEQ_RESET;
                end
            endcase
        end
    end

    assign pm_addr   = pm_addr_q;
    assign pc        = pc_q;
    assign stack_err = stack_err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios followed by
// randomized stimulus, all compared against a queue-based reference model.
module tb_program_sequencer;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          jmp = 1'b0, jmp_nz = 1'b0, dont_jmp = 1'b0;
    logic          call = 1'b0, ret = 1'b0, hold = 1'b0;
    logic [3:0]    jmp_addr = 4'h0;
    logic [AW-1:0] pm_addr, pc;
    logic          stack_err;
    logic [1:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pm, m_pc, m_err, m_state;
    int m_stk[$];

    program_sequencer #(.PM_ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .jmp       (jmp),
        .jmp_nz    (jmp_nz),
        .jmp_addr  (jmp_addr),
        .dont_jmp  (dont_jmp),
        .call      (call),
        .ret       (ret),
        .hold      (hold),
        .pm_addr   (pm_addr),
        .pc        (pc),
        .stack_err (stack_err),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".pm_addr"},   int'(pm_addr),   m_pm);
        check_eq({tag, ".pc"},        int'(pc),        m_pc);
        check_eq({tag, ".stack_err"}, int'(stack_err), m_err);
        check_eq({tag, ".state"},     int'(state),     m_state);
    endtask

    task automatic model_reset();
        m_pm = 0; m_pc = 0; m_err = 0; m_state = 0;
        m_stk.delete();
    endtask

    // One clock: drive inputs at the falling edge, apply the rules at the rising
    // edge, compare at the next falling edge.
    task automatic step(input bit h, input bit j, input bit jnz, input bit dj,
                        input bit c, input bit r, input logic [3:0] a, input string tag);
        int nxt;
        hold = h; jmp = j; jmp_nz = jnz; dont_jmp = dj; call = c; ret = r; jmp_addr = a;
        @(posedge clk);
        if (m_state == 0) begin
            m_pc = m_pm; m_pm = 0; m_state = 1;
        end else if (h) begin
            m_state = 2;
        end else begin
            nxt = (m_pm + 1) % 256;
            if (r) begin
                if (m_stk.size() > 0) nxt = m_stk.pop_back();
                else m_err = 1;
            end else if (c) begin
                nxt = int'(a) * 16;
                if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % 256);
                else m_err = 1;
            end else if (j || (jnz && !dj)) begin
                nxt = int'(a) * 16;
            end
            m_pc = m_pm; m_pm = nxt; m_state = 1;
        end
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, tag);
    endtask

    // Assert reset between edges, check the immediate effect, release one edge later.
    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_model(tag);
        @(negedge clk);
        check_model({tag, ".held"});
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_model("reset");
        @(negedge clk);
        @(negedge clk);
        check_model("reset_low");
        reset_n = 1'b1;

        // Free-running count with wrap
        for (int k = 1; k <= 260; k++) begin
            idle("count");
            check_eq("count.seq", int'(pm_addr), (k - 1) % 256);
        end

        // Jump and suppressed conditional jump
        pulse_reset("rst1");
        for (int k = 0; k < 6; k++) idle("to05");
        check_eq("at05", int'(pm_addr), 32'h05);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, "jmp");
        check_eq("jmp.A0", int'(pm_addr), 32'hA0);
        idle("A1");
        check_eq("jmp.A1", int'(pm_addr), 32'hA1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, "jnz_supp");
        check_eq("jnz.A2", int'(pm_addr), 32'hA2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, "jnz_take");
        check_eq("jnz.10", int'(pm_addr), 32'h10);

        // Call / ret
        idle("to11");
        check_eq("pc10", int'(pc), 32'h10);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, "call3");
        check_eq("call.30", int'(pm_addr), 32'h30);
        idle("31");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, "ret");
        check_eq("ret.11", int'(pm_addr), 32'h11);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(k + 4), "nest");
        check_eq("nest.err0", int'(stack_err), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h8, "call_full");
        check_eq("full.80", int'(pm_addr), 32'h80);
        check_eq("full.err", int'(stack_err), 1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, "unnest");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, "ret_empty");
        check_eq("empty.err", int'(stack_err), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9, "call_ret");

        // Hold drops requests
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, "to20");
        idle("21");
        idle("22");
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, "hold");
            check_eq("hold.22", int'(pm_addr), 32'h22);
            check_eq("hold.st", int'(state), 2);
        end
        idle("resume");
        check_eq("resume.23", int'(pm_addr), 32'h23);

        // Reset during hold with two stacked entries
        pulse_reset("rst2");
        idle("r2a");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, "c1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6, "c2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, "h");
        pulse_reset("rst_hold");
        idle("post_rst");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, "ret_after_rst");
        check_eq("rst.stack_empty", int'(stack_err), 1);

        // Randomized traffic
        pulse_reset("rst3");
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
                     4'($urandom_range(0, 15)), "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter PM_ADDR_W, default 8, program-memory address width.
REQ-002 Parameter STACK_DEPTH, default 4, return-stack entries.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 jmp  input  1  unconditional jump request from instruction decoder.
REQ-006 jmp_nz  input  1  conditional jump request, taken only when dont_jmp=0.
REQ-007 jmp_addr  input  4  target nibble (decoder ir_nibble); target = {jmp_addr, 4'h0}.
REQ-008 dont_jmp  input  1  registered zero flag; 1 suppresses jmp_nz.
REQ-009 call  input  1  jump to {jmp_addr,4'h0} and push return address pc+1.
REQ-010 ret  input  1  pop return stack into pm_addr.
REQ-011 hold  input  1  stall: freeze pm_addr, pc and stack.
REQ-012 pm_addr  output  PM_ADDR_W  registered program-memory address.
REQ-013 pc  output  PM_ADDR_W  address of instruction currently in decoder (pm_addr delayed one cycle).
REQ-014 stack_err  output  1  sticky flag: push when full or pop when empty.
REQ-015 state  output  2  current FSM state for debug.

Function
REQ-016 FSM states SEQ_RESET, SEQ_RUN, SEQ_HOLD; SEQ_RESET left on first clock after reset_n deasserts, entering SEQ_RUN with pm_addr=0.
REQ-017 SEQ_RUN -> SEQ_HOLD when hold=1; SEQ_HOLD -> SEQ_RUN on first edge with hold=0; hold has priority over all other inputs.
REQ-018 In SEQ_RUN, next pm_addr priority: ret, then call, then jmp, then (jmp_nz & ~dont_jmp), else pm_addr+1.
REQ-019 Taken branch/call/ret: pm_addr updates on the same edge the request is sampled; no bubble inserted by sequencer.
REQ-020 Increment wraps modulo 2^PM_ADDR_W (8'hFF -> 8'h00), no flag.
REQ-021 pc <= pm_addr on every non-hold edge; pc unchanged in SEQ_HOLD.
REQ-022 call pushes pc+1 (modulo width); ret pops top entry; LIFO order.
REQ-023 call when stack full: no push, jump still taken, stack_err set.
REQ-024 ret when stack empty: pm_addr <= pm_addr+1, stack_err set.
REQ-025 call and ret sampled together: ret wins, no push, no error.
REQ-026 jmp and jmp_nz together: jmp wins (same target).
REQ-027 stack_err remains 1 until reset.
REQ-028 Requests arriving while hold=1 are ignored, not queued.

Reset
REQ-029 reset_n=0 forces immediately: pm_addr=0, pc=0, stack empty, stack_err=0, state=SEQ_RESET.
REQ-030 Reset asserted mid-operation (including SEQ_HOLD or mid-call) discards stack contents; no partial update survives.
REQ-031 Reset deassertion is synchronised externally; block does not resynchronise.

Structure
REQ-032 Shared package mpu_pkg holds PM_ADDR_W, STACK_DEPTH defaults and seq_state_t encoding (SEQ_RESET=0, SEQ_RUN=1, SEQ_HOLD=2).
REQ-033 One sub-module return_stack: push, pop, data in/out, full, empty, same clk/reset_n.
REQ-034 Next-address mux combinational; pm_addr, pc, state, stack_err registered.

Verification
REQ-035 Reset release, no requests, 260 cycles -> pm_addr counts 0..FF, wraps to 00, pc trails by one cycle.
REQ-036 jmp=1, jmp_addr=4'hA at pm_addr=05 -> next pm_addr=A0, then A1; jmp_nz=1 with dont_jmp=1 at A1 -> A2.
REQ-037 call jmp_addr=3 with pc=10 -> pm_addr=30; later ret -> pm_addr=11; 4 nested calls then 4 rets return in LIFO order.
REQ-038 5th call with stack full -> jump taken, stack_err=1; ret on empty stack -> pm_addr+1, stack_err stays 1.
REQ-039 hold=1 for 3 cycles at pm_addr=22 with jmp=1 -> pm_addr stays 22, state=SEQ_HOLD, jump dropped; resume at 23.
REQ-040 reset_n pulsed low between edges during SEQ_HOLD with 2 stacked entries -> outputs 0 immediately, stack empty, state=SEQ_RESET.
